// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Purpose : XLEN, the default NOP encoding and the {pc, inst} entry held in the fetch queue.
package if_fetch_stage_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - DEPTH-entry synchronous FIFO of fetched {pc, inst} entries
//
// Purpose : registered fetch queue between imem responses and the IF/ID register.
// Ports   : clk, rst_n (async, active-low)
//           push_i / data_i   - write data_i at the tail
//           pop_i             - drop the head (caller only pops when count_o != 0)
//           flush_i           - empty the queue; wins over push/pop
//           data_o            - head entry (undefined contents when count_o == 0)
//           count_o           - number of valid entries, 0..DEPTH
module if_fetch_queue
  import if_fetch_stage_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset: count_q qualifies every read.
  // Push+pop while full is safe: the head is read before the slot is overwritten.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage: PC, credit-limited imem reads, fetch queue, redirect
//
// Purpose : owns the fetch PC, issues in-order imem reads while (queued + outstanding) < QDEPTH,
//           buffers responses in if_fetch_queue and presents {if_pc, if_inst} to IF/ID.
//           A redirect flushes the queue and discards every response still in flight.
// Ports   : clk, rst (async, active-low)
//           imem_req/imem_addr            - read request, word aligned
//           imem_rvalid/imem_rdata        - in-order responses, latency >= 1
//           redirect_valid/redirect_pc    - taken branch/jump pulse from EX
//           if_valid/if_ready/if_pc/if_inst - queue head towards IF/ID (NOP_INST when empty)
// Option  : IF_FETCH_PERF_EN adds perf_stall_cyc and perf_redirects (saturating counters).
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2,
  parameter logic [XLEN-1:0] NOP_INST = if_fetch_stage_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cyc,
  output logic [31:0]     perf_redirects
`endif
);

  localparam int            CW         = $clog2(QDEPTH + 1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(QDEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tail_pc_q, tail_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   q_count;
  logic            issue, resp, push, pop;
  fetch_entry_t    q_in, q_head;
  logic            unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];

  // Queued entries plus in-flight reads bound queue occupancy, so pushes never overflow.
  assign issue = rst && !redirect_valid && (({1'b0, q_count} + {1'b0, outst_q}) < CREDIT_MAX);
  // A response with nothing outstanding is out of contract; ignore it rather than underflow.
  assign resp  = imem_rvalid && (outst_q != '0);
  assign push  = resp && !redirect_valid && (drop_q == '0);
  assign pop   = if_valid && if_ready && !redirect_valid;

  assign q_in.pc   = tail_pc_q;
  assign q_in.inst = imem_rdata;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tail_pc_d  = tail_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q;
    if (issue && !resp)      outst_d = outst_q + 1'b1;
    else if (!issue && resp) outst_d = outst_q - 1'b1;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      tail_pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
      // Everything still in flight after this cycle is stale; no issue happens this cycle.
      drop_d     = outst_q - CW'(resp);
    end else begin
      if (issue)                 fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)                  tail_pc_d  = tail_pc_q + 32'd4;
      if (resp && drop_q != '0)  drop_d     = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      tail_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tail_pc_q  <= tail_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  if_fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  (q_in),
    .data_o  (q_head),
    .count_o (q_count)
  );

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign if_valid  = (q_count != '0);
  assign if_pc     = if_valid ? q_head.pc   : '0;
  assign if_inst   = if_valid ? q_head.inst : NOP_INST;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] stall_cyc_q, redirects_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cyc_q <= '0;
      redirects_q <= '0;
    end else begin
      if (!if_valid && if_ready && stall_cyc_q != 32'hFFFF_FFFF) stall_cyc_q <= stall_cyc_q + 32'd1;
      if (redirect_valid && redirects_q != 32'hFFFF_FFFF)       redirects_q <= redirects_q + 32'd1;
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  localparam int          QD  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_redirects;
`endif

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_redirects (perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: memory requests tagged with the redirect epoch they were issued in;
  // only current-epoch responses reach the consumer, in request order.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  req_t        pend[$];
  ent_t        mq[$];
  logic [31:0] log_pc[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          issued = 0;
  int          stall_exp = 0;
  int          redir_exp = 0;
  logic [31:0] exp_issue = RPC;
  logic [31:0] salt = '0;
  logic        last_req = 1'b0;
  bit          found;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic logic [31:0] lg(input int i);
    if (i < log_pc.size()) return log_pc[i];
    return 'x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, NOP);
`ifdef IF_FETCH_PERF_EN
    chk("rst_perf_stall", perf_stall_cyc, 32'd0);
    chk("rst_perf_redir", perf_redirects, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    pend.delete();
    mq.delete();
    log_pc.delete();
    exp_issue = RPC;
    epoch = 0;
    last_due = cyc;
    issued = 0;
    stall_exp = 0;
    redir_exp = 0;
  endtask

  // One clock: drive at negedge (also releases reset), sample 1ns later, advance the model.
  task automatic cycle(input bit rdy, input bit rd, input logic [31:0] rpc);
    bit   resp_now;
    bit   exp_req;
    req_t r;
    ent_t e;
    int   d;
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    if_ready = rdy;
    redirect_valid = rd;
    redirect_pc = rpc;
    resp_now = (pend.size() > 0);
    if (resp_now) resp_now = (pend[0].due <= cyc);
    imem_rvalid = resp_now;
    if (resp_now) imem_rdata = memfn(pend[0].addr);
    else          imem_rdata = $urandom();
    #1;
    exp_req = !rd && ((mq.size() + pend.size()) < QD);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("if_valid", 32'(if_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("if_pc", if_pc, mq[0].pc);
      chk("if_inst", if_inst, mq[0].inst);
    end else begin
      chk("if_pc_idle", if_pc, 32'd0);
      chk("if_inst_nop", if_inst, NOP);
    end
    if (imem_req) chk("imem_addr", imem_addr, exp_issue);
`ifdef IF_FETCH_PERF_EN
    chk("perf_stall", perf_stall_cyc, 32'(stall_exp));
    chk("perf_redir", perf_redirects, 32'(redir_exp));
    if (mq.size() == 0 && rdy) stall_exp++;
    if (rd) redir_exp++;
`endif
    last_req = imem_req;
    if (rdy && !rd && mq.size() > 0) begin
      log_pc.push_back(if_pc);
      mq.delete(0);
    end
    if (resp_now) begin
      r = pend.pop_front();
      if (!rd && r.epoch == epoch) begin
        e.pc = r.addr;
        e.inst = memfn(r.addr);
        mq.push_back(e);
      end
    end
    if (imem_req) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      r.addr = exp_issue;
      r.due = d;
      r.epoch = epoch;
      pend.push_back(r);
      exp_issue = exp_issue + 32'd4;
      issued++;
    end
    if (rd) begin
      epoch++;
      exp_issue = rpc & ~32'h3;
      mq.delete();
    end
  endtask

  initial begin
    salt = $urandom();

    // Streaming from reset, latency 1
    lat_min = 1; lat_max = 1;
    do_reset();
    cycle(1'b1, 1'b0, '0);
    chk("first_req", 32'(last_req), 32'd1);
    repeat (11) cycle(1'b1, 1'b0, '0);
    chk("seq0", lg(0), 32'h0);
    chk("seq1", lg(1), 32'h4);
    chk("seq2", lg(2), 32'h8);

    // Back-pressure: credit limit stops issue at QD requests
    do_reset();
    repeat (6) cycle(1'b0, 1'b0, '0);
    chk("hold_issued", 32'(issued), 32'd2);
    chk("hold_req_off", 32'(last_req), 32'd0);
    chk("hold_pc", if_pc, 32'h0);
    repeat (4) cycle(1'b1, 1'b0, '0);
    chk("drain0", lg(0), 32'h0);
    chk("drain1", lg(1), 32'h4);

    // Redirect with two reads in flight, latency 2
    do_reset();
    lat_min = 2; lat_max = 2;
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    log_pc.delete();
    cycle(1'b1, 1'b1, 32'h0000_1003);
    repeat (10) cycle(1'b1, 1'b0, '0);
    chk("redir0", lg(0), 32'h1000);
    chk("redir1", lg(1), 32'h1004);

    // Redirect coinciding with a response and a pop
    do_reset();
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b1, 1'b0, '0);
      if (mq.size() > 0 && pend.size() > 0)
        if (pend[0].due <= cyc + 1) found = 1'b1;
    end
    chk("coinc_found", 32'(found), 32'd1);
    log_pc.delete();
    cycle(1'b1, 1'b1, 32'h0000_2000);
    chk("coinc_valid", 32'(if_valid), 32'd1);
    cycle(1'b1, 1'b0, '0);
    chk("flush_empty", 32'(if_valid), 32'd0);
    repeat (6) cycle(1'b1, 1'b0, '0);
    chk("coinc_target", lg(0), 32'h2000);

    // Address wrap at the top of the address space
    log_pc.delete();
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (12) cycle(1'b1, 1'b0, '0);
    chk("wrap0", lg(0), 32'hFFFF_FFF8);
    chk("wrap1", lg(1), 32'hFFFF_FFFC);
    chk("wrap2", lg(2), 32'h0000_0000);
    chk("wrap3", lg(3), 32'h0000_0004);

`ifdef IF_FETCH_PERF_EN
    // 3 redirects, then 5 empty-and-ready cycles counted before the third plain cycle
    do_reset();
    cycle(1'b1, 1'b1, 32'h100);
    cycle(1'b1, 1'b1, 32'h200);
    cycle(1'b1, 1'b1, 32'h300);
    repeat (3) cycle(1'b1, 1'b0, '0);
    chk("perf_redir3", perf_redirects, 32'd3);
    chk("perf_stall5", perf_stall_cyc, 32'd5);
`endif

    // Randomized traffic with variable latency and one mid-run reset
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset();
      cycle($urandom_range(3, 0) != 0, $urandom_range(23, 0) == 0, $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
